// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode tags, result record and
// the occupancy states of the result stage's skid buffer.
package alu_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int ALU_OPW   = 3;

  localparam logic [ALU_OPW-1:0] OP_AND  = 3'd0;
  localparam logic [ALU_OPW-1:0] OP_OR   = 3'd1;
  localparam logic [ALU_OPW-1:0] OP_XOR  = 3'd2;
  localparam logic [ALU_OPW-1:0] OP_NAND = 3'd3;
  localparam logic [ALU_OPW-1:0] OP_NOR  = 3'd4;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic [ALU_OPW-1:0]   op;
    logic                 zero;
    logic                 ones;
    logic                 parity;
  } alu_res_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero / all-ones / parity flags for one gate result word.
module alu_flag_gen #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_result,
  output logic             o_zero,
  output logic             o_ones,
  output logic             o_parity
);

  assign o_zero   = ~|i_result;
  assign o_ones   = &i_result;
  assign o_parity = ^i_result;

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage for the bitwise gate units: flags captured at input,
// two-entry valid/ready skid buffer toward writeback, wrapping delivery counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [OPW-1:0]   out_op,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [CNT_W-1:0] res_count,
  output logic             count_wrap
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [OPW-1:0]   op;
    logic             zero;
    logic             ones;
    logic             parity;
  } entry_t;

  skid_state_t      r_state;
  logic             r_main_vld;
  logic             r_skid_vld;
  entry_t           r_main;
  entry_t           r_skid;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;

  entry_t           w_in_entry;
  logic             w_zero;
  logic             w_ones;
  logic             w_parity;
  logic             w_in_fire;
  logic             w_out_fire;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
    .i_result (in_result),
    .o_zero   (w_zero),
    .o_ones   (w_ones),
    .o_parity (w_parity)
  );

  assign w_in_entry = '{result: in_result, op: in_op,
                        zero: w_zero, ones: w_ones, parity: w_parity};

  // in_ready comes from the skid flag only, so out_ready never reaches it.
  assign in_ready   = rst_n & ~r_skid_vld;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_main_vld & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
      r_cnt      <= '0;
      r_wrap     <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_main     <= w_in_entry;
            r_main_vld <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= w_in_entry;
          end else if (w_in_fire) begin
            r_skid     <= w_in_entry;
            r_skid_vld <= 1'b1;
            r_state    <= ST_FULL;
          end else if (w_out_fire) begin
            r_main_vld <= 1'b0;
            r_state    <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_main     <= r_skid;
            r_skid_vld <= 1'b0;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_main_vld <= 1'b0;
          r_skid_vld <= 1'b0;
        end
      endcase

      if (w_out_fire) begin
        r_cnt <= r_cnt + 1'b1;
        if (&r_cnt) r_wrap <= 1'b1;
      end
    end
  end

  assign out_valid  = r_main_vld;
  assign out_result = r_main.result;
  assign out_op     = r_main.op;
  assign out_zero   = r_main.zero;
  assign out_ones   = r_main.ones;
  assign out_parity = r_main.parity;
  assign res_count  = r_cnt;
  assign count_wrap = r_wrap;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: queue-based reference model checked on
// every falling edge, plus literal expectations for each scenario.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_result = 4'h0;
  logic [2:0] in_op = 3'h0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_zero, out_ones, out_parity, count_wrap;
  logic [3:0] out_result;
  logic [2:0] out_op;
  logic [7:0] res_count;

  logic       in_ready2, out_valid2, out_zero2, out_ones2, out_parity2, count_wrap2;
  logic [3:0] out_result2;
  logic [2:0] out_op2;
  logic [1:0] res_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(4), .OPW(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
    .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
    .res_count(res_count), .count_wrap(count_wrap)
  );

  alu_result_stage #(.WIDTH(4), .OPW(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_result(in_result), .in_op(in_op), .out_valid(out_valid2),
    .out_ready(out_ready), .out_result(out_result2), .out_op(out_op2),
    .out_zero(out_zero2), .out_ones(out_ones2), .out_parity(out_parity2),
    .res_count(res_count2), .count_wrap(count_wrap2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two words, plus plain integer counters.
  typedef struct { logic [3:0] r; logic [2:0] op; } ent_t;
  ent_t m_q[$];
  int   m_cnt = 0;
  bit   m_wrap8 = 0, m_wrap2 = 0;
  bit   started = 0;
  logic [3:0] log_res[$];
  logic       log_par[$];

  function automatic logic par_of(input logic [3:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt = 0; m_wrap8 = 0; m_wrap2 = 0;
      started = 1;
    end else if (started) begin
      bit fin, fout;
      ent_t e;
      fin  = in_valid && (m_q.size() < 2);
      fout = out_ready && (m_q.size() > 0);
      if (fout) begin
        void'(m_q.pop_front());
        if (m_cnt % 256 == 255) m_wrap8 = 1;
        if (m_cnt % 4 == 3) m_wrap2 = 1;
        m_cnt++;
      end
      if (fin) begin
        e.r = in_result; e.op = in_op;
        m_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, rst_n && (m_q.size() < 2));
      chk("in_ready2", in_ready2, rst_n && (m_q.size() < 2));
      chk("out_valid", out_valid, m_q.size() > 0);
      chk("out_valid2", out_valid2, m_q.size() > 0);
      chk("res_count", res_count, m_cnt % 256);
      chk("res_count2", res_count2, m_cnt % 4);
      chk("count_wrap", count_wrap, m_wrap8);
      chk("count_wrap2", count_wrap2, m_wrap2);
      if (m_q.size() > 0) begin
        chk("out_result", out_result, m_q[0].r);
        chk("out_result2", out_result2, m_q[0].r);
        chk("out_op", out_op, m_q[0].op);
        chk("out_zero", out_zero, m_q[0].r == 4'h0);
        chk("out_ones", out_ones, m_q[0].r == 4'hF);
        chk("out_parity", out_parity, par_of(m_q[0].r));
        chk("out_parity2", out_parity2, par_of(m_q[0].r));
        chk("out_zero2", out_zero2, m_q[0].r == 4'h0);
        chk("out_ones2", out_ones2, m_q[0].r == 4'hF);
        chk("out_op2", out_op2, m_q[0].op);
      end
      if (rst_n && out_valid && out_ready) begin
        log_res.push_back(out_result);
        log_par.push_back(out_parity);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit accepted;
    // Reset held two cycles with a word offered upstream
    rst_n = 1'b0; in_valid = 1'b1; in_result = 4'h5; in_op = OP_AND;
    cyc(); cyc();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", res_count, 8'd0);
    chk("rst_out_result", out_result, 4'h0);
    rst_n = 1'b1; in_valid = 1'b0;
    cyc();
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Single result 0000 from NAND
    in_valid = 1'b1; in_result = 4'b0000; in_op = OP_NAND; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1'b1);
    chk("single_result", out_result, 4'h0);
    chk("single_op", out_op, OP_NAND);
    chk("single_zero", out_zero, 1'b1);
    chk("single_ones", out_ones, 1'b0);
    chk("single_parity", out_parity, 1'b0);
    cyc();
    chk("single_count", res_count, 8'd1);
    chk("single_drained", out_valid, 1'b0);

    // Backpressure: fill both entries, third word held upstream
    out_ready = 1'b0;
    log_res.delete(); log_par.delete();
    in_valid = 1'b1; in_result = 4'hF; in_op = OP_OR;
    cyc();
    in_result = 4'h6; in_op = OP_XOR;
    cyc();
    in_result = 4'hA; in_op = OP_AND;
    cyc();
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head", out_result, 4'hF);
    chk("bp_ones", out_ones, 1'b1);
    cyc();
    chk("bp_head_hold", out_result, 4'hF);
    chk("bp_in_ready_hold", in_ready, 1'b0);
    out_ready = 1'b1;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) begin
        cyc();
        in_valid = 1'b0;
        accepted = 1;
        break;
      end
      cyc();
    end
    chk("bp_accept_timeout", accepted, 1'b1);
    in_valid = 1'b0;
    cyc(); cyc();
    chk("bp_log_len", log_res.size(), 3);
    if (log_res.size() == 3) begin
      chk("bp_order0", log_res[0], 4'hF);
      chk("bp_order1", log_res[1], 4'h6);
      chk("bp_order2", log_res[2], 4'hA);
      chk("bp_par0", log_par[0], 1'b0);
      chk("bp_par1", log_par[1], 1'b0);
      chk("bp_par2", log_par[2], 1'b0);
    end
    chk("bp_count", res_count, 8'd4);
    chk("bp_count2", res_count2, 2'd0);
    chk("bp_wrap2", count_wrap2, 1'b1);

    // Streaming 16 words back to back
    log_res.delete(); log_par.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_result = 4'(i); in_op = 3'(i % 5);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_len", log_res.size(), 16);
    if (log_res.size() == 16) chk("stream_last", log_res[15], 4'hF);
    chk("stream_count", res_count, 8'd20);
    chk("stream_count2", res_count2, 2'd0);
    chk("stream_wrap", count_wrap, 1'b0);

    // Simultaneous input and output while holding one word
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 4'b0011; in_op = OP_AND;
    cyc();
    out_ready = 1'b1; in_result = 4'b0101; in_op = OP_OR;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("simul_valid", out_valid, 1'b1);
    chk("simul_result", out_result, 4'b0101);
    chk("simul_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("simul_count", res_count, 8'd22);

    // Reset while full discards both entries and clears the sticky wrap
    in_valid = 1'b1; in_result = 4'h7;
    cyc();
    in_result = 4'h9;
    cyc();
    chk("mid_full", in_ready, 1'b0);
    rst_n = 1'b0; in_valid = 1'b0;
    cyc();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_count", res_count, 8'd0);
    chk("mid_rst_wrap2", count_wrap2, 1'b0);
    chk("mid_rst_result", out_result, 4'h0);
    rst_n = 1'b1;
    cyc();
    chk("mid_post_ready", in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
